sprite_rom_arbiter: RTL and testbench

- Shares one synchronous sprite ROM read port among NREQ requesters (fighter sprites, HUD, background).
- Uses round-robin arbitration with an optional starvation-free priority lane for requester 0 (background, which must hit every pixel slot).
- Sits between the per-sprite draw units and the single ROM/palette pair.
- Returns ROM data to the winning requester with a tagged one-cycle-latency response.

---
 rtl/sprite_pkg.sv | 13 +
 rtl/sprite_rom_arbiter_if.sv | 30 +++
 rtl/sprite_rom_arbiter_rr_pick.sv | 30 +++
 rtl/sprite_rom_arbiter.sv | 94 +++++++++
 tb/tb_sprite_rom_arbiter.sv | 161 ++++++++++++++++
 5 files changed

// File: rtl/sprite_pkg.sv
// Shared sprite ROM types and constants for the sprite-path arbiters.
package sprite_pkg;

  localparam int unsigned SPR_AW = 12;
  localparam int unsigned SPR_DW = 4;

  typedef logic [SPR_AW-1:0] spr_addr_t;
  typedef logic [SPR_DW-1:0] pal_idx_t;

  localparam int unsigned BUSY_W   = 16;
  localparam logic [BUSY_W-1:0] BUSY_MAX = 16'hFFFF;

endpackage

// File: rtl/sprite_rom_arbiter_if.sv
// Requester/ROM bus of the sprite ROM arbiter: requests, ROM port and tagged responses.
interface sprite_rom_arbiter_if
  import sprite_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned AW   = SPR_AW,
  parameter int unsigned DW   = SPR_DW
) ();

  logic [NREQ-1:0]    req;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ-1:0]    gnt;
  logic [AW-1:0]      rom_address;
  logic               rom_rd;
  logic [DW-1:0]      rom_q;
  logic [NREQ-1:0]    rsp_valid;
  logic [DW-1:0]      rsp_data;
  logic [BUSY_W-1:0]  busy_cnt;

  modport slave (
    input  req, req_addr, rom_q,
    output gnt, rom_address, rom_rd, rsp_valid, rsp_data, busy_cnt
  );

  modport master (
    output req, req_addr, rom_q,
    input  gnt, rom_address, rom_rd, rsp_valid, rsp_data, busy_cnt
  );

endinterface

// File: rtl/sprite_rom_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module rr_pick #(
  parameter int unsigned N  = 4,
  parameter int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  onehot,
  output logic [PW-1:0] idx,
  output logic          any
);

  always_comb begin
    int unsigned i;
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      // Explicit wrap compare keeps non-power-of-two N correct.
      i = int'(ptr) + k;
      if (i >= N) i = i - N;
      if (!any && req[i]) begin
        any       = 1'b1;
        onehot[i] = 1'b1;
        idx       = PW'(i);
      end
    end
  end

endmodule

// File: rtl/sprite_rom_arbiter.sv
// Shares one sprite ROM read port among NREQ draw units; optional fixed priority for requester 0.
module sprite_rom_arbiter
  import sprite_pkg::*;
#(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned AW    = SPR_AW,
  parameter int unsigned DW    = SPR_DW,
  parameter bit          PRIO0 = 1'b1
) (
  input  logic                 vga_clk,
  input  logic                 reset,
  sprite_rom_arbiter_if.slave  bus
);

  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [NREQ-1:0]   rr_onehot;
  logic [PW-1:0]     rr_idx;
  logic              rr_any;
  logic              prio_hit;
  logic [NREQ-1:0]   gnt;
  logic [PW-1:0]     win_idx;
  logic [NREQ-1:0]   rsp_valid_q;
  logic [DW-1:0]     rsp_data_q;
  logic [BUSY_W-1:0] busy_q, busy_d;

  rr_pick #(
    .N  (NREQ),
    .PW (PW)
  ) u_rr_pick (
    .req    (bus.req),
    .ptr    (rr_ptr_q),
    .onehot (rr_onehot),
    .idx    (rr_idx),
    .any    (rr_any)
  );

  assign prio_hit = PRIO0 && bus.req[0];

  always_comb begin
    gnt     = '0;
    win_idx = '0;
    if (!reset) begin
      if (prio_hit) begin
        gnt[0]  = 1'b1;
        win_idx = '0;
      end else if (rr_any) begin
        gnt     = rr_onehot;
        win_idx = rr_idx;
      end
    end
  end

  // Only round-robin grants advance the pointer; priority grants leave it alone.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (!reset && !prio_hit && rr_any) begin
      rr_ptr_d = (rr_idx == PW'(NREQ - 1)) ? '0 : rr_idx + 1'b1;
    end
  end

  always_comb begin
    busy_d = busy_q;
    if (|(bus.req & ~gnt) && (busy_q != BUSY_MAX)) begin
      busy_d = busy_q + 1'b1;
    end
  end

  // ROM runs on the falling edge, so rom_q for a cycle-T read is ready at the T+1 edge.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      rr_ptr_q    <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      busy_q      <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      rsp_valid_q <= gnt;
      rsp_data_q  <= bus.rom_q;
      busy_q      <= busy_d;
    end
  end

  always_comb begin
    bus.gnt         = gnt;
    bus.rom_rd      = |gnt;
    bus.rom_address = (|gnt) ? bus.req_addr[int'(win_idx)*AW +: AW] : '0;
    bus.rsp_valid   = rsp_valid_q;
    bus.rsp_data    = rsp_data_q;
    bus.busy_cnt    = busy_q;
  end

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Drives a round-robin and a priority instance with shared stimulus against a reference model.
module tb_sprite_rom_arbiter;

  localparam int NR = 4;
  localparam int AWB = 12;
  localparam int DWB = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     req;
  logic [NR*AWB-1:0] addr;

  int n_vec = 0;
  int n_err = 0;

  int          m_ptr  [2];
  int          m_busy [2];
  logic [3:0]  m_rv   [2];
  logic [3:0]  m_rd   [2];

  always #5 clk = ~clk;

  sprite_rom_arbiter_if #(.NREQ(NR), .AW(AWB), .DW(DWB)) if_rr ();
  sprite_rom_arbiter_if #(.NREQ(NR), .AW(AWB), .DW(DWB)) if_pr ();

  assign if_rr.req      = req;
  assign if_rr.req_addr = addr;
  assign if_pr.req      = req;
  assign if_pr.req_addr = addr;

  sprite_rom_arbiter #(.NREQ(NR), .AW(AWB), .DW(DWB), .PRIO0(1'b0)) u_rr (
    .vga_clk (clk),
    .reset   (rst),
    .bus     (if_rr.slave)
  );

  sprite_rom_arbiter #(.NREQ(NR), .AW(AWB), .DW(DWB), .PRIO0(1'b1)) u_pr (
    .vga_clk (clk),
    .reset   (rst),
    .bus     (if_pr.slave)
  );

  function automatic logic [3:0] rom_fn(input logic [11:0] a);
    return a[3:0] ^ a[7:4] ^ a[11:8] ^ 4'h5;
  endfunction

  // Behavioural ROM clocked on the falling edge.
  always @(negedge clk) begin
    if_rr.rom_q <= rom_fn(if_rr.rom_address);
    if_pr.rom_q <= rom_fn(if_pr.rom_address);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_check(input int d, input bit prio, input logic [3:0] o_gnt,
                             input logic [11:0] o_addr, input logic o_rd,
                             input logic [3:0] o_rv, input logic [3:0] o_rdata,
                             input logic [15:0] o_busy);
    string nm;
    int w;
    logic [3:0]  e_gnt;
    logic [11:0] e_addr;
    nm = d ? "prio" : "rr";
    w  = -1;
    if (!rst) begin
      if (prio && req[0]) w = 0;
      else
        for (int k = 0; k < NR; k++) begin
          int i;
          i = (m_ptr[d] + k) % NR;
          if (w < 0 && req[i]) w = i;
        end
    end
    e_gnt  = (w >= 0) ? 4'(1 << w) : 4'h0;
    e_addr = (w >= 0) ? addr[w*AWB +: AWB] : 12'h0;
    check_eq({nm, ".gnt"}, 32'(o_gnt), 32'(e_gnt));
    check_eq({nm, ".rom_address"}, 32'(o_addr), 32'(e_addr));
    check_eq({nm, ".rom_rd"}, 32'(o_rd), 32'(w >= 0));
    check_eq({nm, ".rsp_valid"}, 32'(o_rv), 32'(m_rv[d]));
    check_eq({nm, ".rsp_data"}, 32'(o_rdata), 32'(m_rd[d]));
    check_eq({nm, ".busy_cnt"}, 32'(o_busy), 32'(m_busy[d]));
    if (rst) begin
      m_ptr[d] = 0; m_busy[d] = 0; m_rv[d] = '0; m_rd[d] = '0;
    end else begin
      m_rv[d] = e_gnt;
      m_rd[d] = rom_fn(e_addr);
      if ((req & ~e_gnt) != 0 && m_busy[d] < 65535) m_busy[d]++;
      if (w >= 0 && !(prio && req[0])) m_ptr[d] = (w + 1) % NR;
    end
  endtask

  task automatic step(input logic r, input logic [3:0] rq, input logic [47:0] ad,
                      input bit chk, input logic [3:0] want_rr, input logic [3:0] want_pr);
    rst = r; req = rq; addr = ad;
    #3;
    if (chk) begin
      check_eq("plan.rr.gnt", 32'(if_rr.gnt), 32'(want_rr));
      check_eq("plan.prio.gnt", 32'(if_pr.gnt), 32'(want_pr));
    end
    model_check(0, 1'b0, if_rr.gnt, if_rr.rom_address, if_rr.rom_rd, if_rr.rsp_valid,
                if_rr.rsp_data, if_rr.busy_cnt);
    model_check(1, 1'b1, if_pr.gnt, if_pr.rom_address, if_pr.rom_rd, if_pr.rsp_valid,
                if_pr.rsp_data, if_pr.busy_cnt);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [47:0] a0;
    logic [3:0]  rr_seq [8];
    a0 = {12'd40, 12'd30, 12'd20, 12'd10};
    rr_seq = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h2, 4'h4, 4'h8};
    for (int d = 0; d < 2; d++) begin
      m_ptr[d] = 0; m_busy[d] = 0; m_rv[d] = '0; m_rd[d] = '0;
    end
    rst = 1'b1; req = '0; addr = '0;
    @(posedge clk);
    #1;

    // Reset held with all requesting.
    for (int c = 0; c < 3; c++) step(1'b1, 4'hF, a0, 1'b1, 4'h0, 4'h0);
    // Round-robin rotation.
    for (int c = 0; c < 8; c++) step(1'b0, 4'hF, a0, 1'b1, rr_seq[c], 4'h1);
    // Priority lane, then requester 0 drops out.
    step(1'b1, 4'h0, a0, 1'b0, 4'h0, 4'h0);
    for (int c = 0; c < 4; c++) step(1'b0, 4'h5, a0, 1'b1, (c % 2) ? 4'h4 : 4'h1, 4'h1);
    step(1'b0, 4'h4, a0, 1'b1, 4'h4, 4'h4);
    // Pointer to 3 then wrap.
    step(1'b1, 4'h0, a0, 1'b0, 4'h0, 4'h0);
    step(1'b0, 4'h4, a0, 1'b1, 4'h4, 4'h4);
    step(1'b0, 4'h9, a0, 1'b1, 4'h8, 4'h1);
    step(1'b0, 4'h9, a0, 1'b1, 4'h1, 4'h1);
    // Requester 1 withdraws before its turn.
    step(1'b1, 4'h0, a0, 1'b0, 4'h0, 4'h0);
    step(1'b0, 4'h3, a0, 1'b1, 4'h1, 4'h1);
    step(1'b0, 4'h1, a0, 1'b1, 4'h1, 4'h1);
    step(1'b0, 4'h0, a0, 1'b1, 4'h0, 4'h0);
    step(1'b0, 4'h4, a0, 1'b1, 4'h4, 4'h4);
    // Reset lands on a would-be grant.
    step(1'b0, 4'h0, a0, 1'b0, 4'h0, 4'h0);
    step(1'b1, 4'h2, a0, 1'b1, 4'h0, 4'h0);
    step(1'b0, 4'h0, a0, 1'b1, 4'h0, 4'h0);
    step(1'b0, 4'hF, a0, 1'b1, 4'h1, 4'h1);

    for (int c = 0; c < 3000; c++) begin
      logic [47:0] ra;
      ra = {$urandom, $urandom};
      step(($urandom_range(0, 63) == 0), 4'($urandom), ra, 1'b0, 4'h0, 4'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
